display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scheduler that shares the single 3-bit-input 7-segment decoder (`decodificador_7seg`) between NUM_DIGITS display digits. It holds a double-buffered set of 3-bit digit codes, drives the decoder inputs A/B/C with one digit's code at a time, and enables that digit's common anode for a fixed dwell time. A blanking gap between digits prevents ghosting. New display values are committed only at frame boundaries.

## Interface
- NUM_DIGITS, 4, digits scanned per frame; legal 1..8
- DWELL, 1000, clocks each digit's anode is driven on; legal ≥1
- BLANK, 2, clocks with all anodes off before each digit slot; legal ≥1
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  scan enable; low forces IDLE
- wr_en  in  1  write request for pending buffer; single-cycle accept, never stalled
- wr_data  in  3*NUM_DIGITS  digit codes; bits [3i+2:3i] belong to digit i, with bit 3i+2 driving A (MSB)
- digit_mask  in  NUM_DIGITS  1 = digit i shown; 0 = anode kept off but slot time still consumed
- wr_busy  out  1  pending buffer holds uncommitted data
- dec_a, dec_b, dec_c  out  1 each  code to the decoder inputs A, B, C (A = MSB)
- an_n  out  NUM_DIGITS  active-low anode enables; at most one bit low at any time
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation
- Storage: active buffer (displayed) and pending buffer, each 3*NUM_DIGITS bits, plus a pending flag (= wr_busy).
- Write: when wr_en=1, wr_data is loaded into the pending buffer and the flag is set. A write while the flag is set overwrites the pending data (latest wins).
- Commit: this occurs on the SHOW→BLANK transition of digit NUM_DIGITS-1.
  - The active buffer takes the pending buffer if the flag is set, and the flag clears.
  - If wr_en is high in the same cycle, the old pending data commits, the new data becomes pending, and the flag stays 1.
- FSM states are IDLE, BLANK, and SHOW. The digit index idx and dwell counter cnt are sized to clog2 of their maxima.
- IDLE: an_n all 1.
  - If enable=1: go to BLANK with idx=0 and cnt=0.
- BLANK: an_n all 1, and dec_* = active code of idx, pre-staged before the anode turns on.
  - After BLANK cycles: go to SHOW with cnt=0.
- SHOW: an_n[idx] = ~digit_mask[idx]; all other bits are 1. dec_* hold the code of idx.
  - After DWELL cycles: go to BLANK, with idx = idx+1, or 0 after idx NUM_DIGITS-1.
  - On the wrap, frame_done pulses and the commit occurs.
- enable=0 in any state: IDLE on the next edge with an_n all 1, idx=0, and cnt=0. A partial frame produces no frame_done and no commit. Buffers and the pending flag are retained.
- digit_mask is sampled every cycle; changing it mid-SHOW changes the anode on the next edge.
- Reset (rst_n=0 at any edge, including mid-frame) produces:
  - state IDLE, idx=0, cnt=0
  - an_n all 1
  - dec_a/b/c=0
  - frame_done=0, wr_busy=0
  - both buffers 0

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Frame period is exactly NUM_DIGITS*(BLANK+DWELL) cycles, independent of digit_mask.
- If enable is sampled high in IDLE at edge k:
  - BLANK occupies cycles k+1 .. k+BLANK.
  - digit 0's anode is low for cycles k+BLANK+1 .. k+BLANK+DWELL.
- dec_* are stable for the whole BLANK+DWELL window of a digit. They change only at the SHOW→BLANK edge.
- frame_done is high for the single cycle following the last digit's final SHOW cycle, i.e. the first BLANK cycle of the next frame.
- Write-to-display latency is at most one frame plus BLANK cycles. The new value first appears on digit 0 in the frame after the commit.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL=4, BLANK=2 (24-cycle frame).
- **Reset:** rst_n=0 for 3 cycles mid-SHOW → an_n=4'b1111, dec=000, wr_busy=0, frame_done=0 on the next edge. After release with enable=1, digit 0 turns on 3 cycles later.
- **Basic scan:** wr_data=12'o7531 (digit0=1, digit1=3, digit2=5, digit3=7), mask=4'b1111 → per slot, 2 blank cycles then 4 cycles with an_n=1110/1101/1011/0111 and codes 001/011/101/111. frame_done pulses every 24 cycles.
- **Double buffering:** write 12'o0000 mid-frame → wr_busy=1 until the frame wrap, then 0. Digits 1–3 keep the old codes until the wrap; the next frame shows 000.
- **Write collision:** wr_en asserted exactly on the commit edge with 12'o2222 while pending holds 12'o1111 → the next frame shows 1, and wr_busy stays 1. The following frame shows 2.
- **Masking:** mask=4'b0101 → an_n shows only 1110 and 1011. Digit 1 and digit 3 slots stay 1111 for their full 6 cycles, and the frame is still 24 cycles.
- **Enable drop:** enable=0 during digit 2's SHOW → IDLE next edge with an_n=1111 and no frame_done. On re-enable, the scan restarts at digit 0 after 2 blank cycles.

Source files
------------

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS 7-segment digits through one shared 3-bit decoder, double-buffered codes.
// Latency: all outputs registered; a write reaches the display at most one frame plus BLANK later.
// Backpressure: none; wr_en is accepted every cycle, and a newer write overwrites uncommitted data.
module display_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [3*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic                    wr_busy,
  output logic                    dec_a,
  output logic                    dec_b,
  output logic                    dec_c,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int BUF_W   = 3 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap;

  logic [BUF_W-1:0]  active_q, active_d;
  logic [BUF_W-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;

  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [2:0]            dec_q, dec_d;
  logic                  frame_done_q, frame_done_d;
  logic [2:0]            code_sel;
  logic [NUM_DIGITS-1:0] sel_oh;

  // State register: scan state, digit index and dwell/blank counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: blank gap, then dwell per digit; enable low aborts to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: buffer commit at frame wrap, pre-staged decoder code, anode select.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (wrap && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    // A write on the commit edge queues behind the data being committed.
    if (wr_en) begin
      pend_d     = wr_data;
      pend_vld_d = 1'b1;
    end

    code_sel = 3'b000;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        code_sel = active_d[3*i +: 3];
      end
    end

    // Decoder input only moves when a new digit slot begins, so it is settled before the anode.
    dec_d = dec_q;
    if (state_d == S_BLANK && state_q != S_BLANK) begin
      dec_d = code_sel;
    end

    sel_oh = NUM_DIGITS'(1) << idx_d;
    an_n_d = '1;
    if (state_d == S_SHOW) begin
      an_n_d = ~(sel_oh & digit_mask);
    end

    frame_done_d = wrap;
  end

  // Buffer registers: displayed codes, pending codes and pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Output registers: every external output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_n_q       <= '1;
      dec_q        <= 3'b000;
      frame_done_q <= 1'b0;
    end else begin
      an_n_q       <= an_n_d;
      dec_q        <= dec_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign dec_a      = dec_q[2];
  assign dec_b      = dec_q[1];
  assign dec_c      = dec_q[0];
  assign frame_done = frame_done_q;
  assign wr_busy    = pend_vld_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios then random traffic.
// Reference model tracks frame position arithmetically (slot = pos / slot length).
// Outputs are compared 1 time unit after every rising edge.
module tb_display_scan_controller;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            wr_en;
  logic [3*ND-1:0] wr_data;
  logic [ND-1:0]   digit_mask;
  logic            wr_busy;
  logic            dec_a, dec_b, dec_c;
  logic [ND-1:0]   an_n;
  logic            frame_done;

  display_scan_controller #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .digit_mask (digit_mask),
    .wr_busy    (wr_busy),
    .dec_a      (dec_a),
    .dec_b      (dec_b),
    .dec_c      (dec_c),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_run;
  int              m_pos;
  logic [3*ND-1:0] m_act, m_pend;
  bit              m_busy;
  logic [2:0]      m_dec;
  logic [ND-1:0]   m_an;
  bit              m_fd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] code_of(input logic [3*ND-1:0] v, input int d);
    return v[3*d +: 3];
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit wrap;
    int slot;
    wrap = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_act = '0; m_pend = '0; m_busy = 0;
      m_dec = '0; m_an = '1; m_fd = 0;
      return;
    end
    if (!enable) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_pos = 0;
    end else begin
      wrap  = (m_pos == FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
    end
    if (wrap && m_busy) begin
      m_act  = m_pend;
      m_busy = 0;
    end
    if (wr_en) begin
      m_pend = wr_data;
      m_busy = 1;
    end
    m_fd = wrap;
    m_an = '1;
    if (m_run) begin
      slot  = m_pos / SLOT;
      m_dec = code_of(m_act, slot);
      if ((m_pos % SLOT) >= BL && digit_mask[slot]) m_an[slot] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("an_n",       32'(an_n),                  32'(m_an));
    check_val("dec",        32'({dec_a, dec_b, dec_c}), 32'(m_dec));
    check_val("frame_done", 32'(frame_done),            32'(m_fd));
    check_val("wr_busy",    32'(wr_busy),               32'(m_busy));
  endtask

  // Step until the model reaches the given frame position (bounded).
  task automatic run_to(input int pos, input string tag);
    for (int i = 0; i < 2 * FRAME && !(m_run && m_pos == pos); i++) step();
    check_val(tag, 32'(m_run && m_pos == pos), 32'd1);
  endtask

  task automatic write(input logic [3*ND-1:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  int n_fd, n_d0, n_d2, n_other;

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = '0; digit_mask = 4'b1111;
    m_run = 0; m_pos = 0; m_act = '0; m_pend = '0; m_busy = 0; m_dec = '0; m_an = '1; m_fd = 0;
    repeat (3) step();
    check_val("rst_an_n", 32'(an_n), 32'hF);
    check_val("rst_busy", 32'(wr_busy), 32'd0);

    // Basic scan: load 7531, first frame shows old zeros, then the new codes.
    rst_n = 1'b1;
    write(12'o7531);
    enable = 1'b1;
    n_fd = 0;
    for (int i = 0; i < 73; i++) begin
      step();
      if (frame_done) n_fd++;
    end
    check_val("basic_fd_count", 32'(n_fd), 32'd3);

    // Reset held 3 cycles mid-SHOW, then restart.
    run_to(10, "reach_show");
    rst_n = 1'b0;
    step();
    check_val("rstmid_an_n", 32'(an_n), 32'hF);
    check_val("rstmid_dec",  32'({dec_a, dec_b, dec_c}), 32'd0);
    check_val("rstmid_fd",   32'(frame_done), 32'd0);
    check_val("rstmid_busy", 32'(wr_busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check_val("rstrel_blank", 32'(an_n), 32'hF);
    step();
    check_val("rstrel_d0_on", 32'(an_n), 32'b1110);

    // Double buffering: write 7531, let it commit, then write 0000 mid-frame.
    run_to(3, "reach_p3");
    write(12'o7531);
    run_to(0, "reach_wrap1");
    check_val("db_busy_clear", 32'(wr_busy), 32'd0);
    run_to(8, "reach_p8");
    write(12'o0000);
    check_val("db_busy_set", 32'(wr_busy), 32'd1);
    run_to(14, "reach_p14");
    check_val("db_old_d2", 32'({dec_a, dec_b, dec_c}), 32'o5);
    run_to(0, "reach_wrap2");
    check_val("db_busy_done", 32'(wr_busy), 32'd0);
    check_val("db_new_d0", 32'({dec_a, dec_b, dec_c}), 32'o0);

    // Write collision on the commit edge.
    run_to(5, "reach_p5");
    write(12'o1111);
    run_to(FRAME - 1, "reach_last");
    write(12'o2222);
    check_val("col_busy", 32'(wr_busy), 32'd1);
    check_val("col_dec",  32'({dec_a, dec_b, dec_c}), 32'o1);
    run_to(FRAME - 1, "reach_last2");
    step();
    check_val("col_next", 32'({dec_a, dec_b, dec_c}), 32'o2);
    check_val("col_busy2", 32'(wr_busy), 32'd0);

    // Masking: only digits 0 and 2 light; frame timing unchanged.
    digit_mask = 4'b0101;
    n_d0 = 0; n_d2 = 0; n_other = 0; n_fd = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an_n == 4'b1110) n_d0++;
      else if (an_n == 4'b1011) n_d2++;
      else if (an_n != 4'b1111) n_other++;
      if (frame_done) n_fd++;
    end
    check_val("mask_d0",    32'(n_d0),    32'd4);
    check_val("mask_d2",    32'(n_d2),    32'd4);
    check_val("mask_other", 32'(n_other), 32'd0);
    check_val("mask_fd",    32'(n_fd),    32'd1);

    // Enable drop in digit 2 SHOW, then restart from digit 0.
    run_to(15, "reach_d2show");
    enable = 1'b0;
    step();
    check_val("drop_an_n", 32'(an_n), 32'hF);
    check_val("drop_fd",   32'(frame_done), 32'd0);
    step(); step();
    enable = 1'b1;
    step(); step();
    check_val("reen_blank", 32'(an_n), 32'hF);
    step();
    check_val("reen_d0", 32'(an_n), 32'b1110);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 999) != 0);
      enable  = ($urandom_range(0, 99) >= 2);
      wr_en   = ($urandom_range(0, 99) < 6);
      wr_data = 12'($urandom);
      if ($urandom_range(0, 99) < 3) digit_mask = 4'($urandom);
      step();
    end
    wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
